// File: rtl/fifo_sync_prog_fwft_if.sv
// Write/read handshake and status bundle for fifo_sync_prog_fwft.
// The FIFO takes the slave view; whatever feeds and drains it takes the master view.
interface fifo_sync_prog_fwft_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int FIFO_WRITE_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_WRITE_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  valid;
    logic                  prog_full;
    logic                  prog_empty;
    logic [CW-1:0]         data_count;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_rst_busy;
    logic                  rd_rst_busy;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, valid, prog_full, prog_empty, data_count,
               overflow, underflow, wr_rst_busy, rd_rst_busy
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, valid, prog_full, prog_empty, data_count,
               overflow, underflow, wr_rst_busy, rd_rst_busy
    );
endinterface

// File: rtl/fifo_sync_prog_fwft.sv
// Single-clock FIFO with std/fwft read modes, programmable thresholds and occupancy count.
// One occupancy counter drives every flag so they all move together on the same edge.
module fifo_sync_prog_fwft #(
    parameter int    FIFO_WRITE_DEPTH  = 16,
    parameter int    DATA_WIDTH        = 32,
    parameter int    PROG_FULL_THRESH  = 12,
    parameter int    PROG_EMPTY_THRESH = 2,
    parameter string READ_MODE         = "std"
) (
    input  logic                 clk,
    input  logic                 srst,
    fifo_sync_prog_fwft_if.slave fifo
);
    localparam int AW = $clog2(FIFO_WRITE_DEPTH);
    localparam int CW = AW + 1;
    localparam bit FWFT = (READ_MODE == "fwft");
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_WRITE_DEPTH);
    localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic [2:0]            busy_sr;
    logic                  busy;
    logic                  full_q;
    logic                  empty_q;
    logic                  pf_q;
    logic                  pe_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  valid_q;
    logic                  valid_nxt;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_ok;
    logic                  pop;
    logic                  arr_rd;
    logic                  arr_empty;
    logic                  rd_legal;

    // Asserts with srst, releases through a short shift chain so busy spans
    // the two edges after release before requests are honoured.
    assign busy = busy_sr[2];

    always_ff @(posedge clk or posedge srst) begin
        if (srst) busy_sr <= '1;
        else      busy_sr <= {busy_sr[1:0], 1'b0};
    end

    always_comb begin
        arr_empty = (wr_ptr == rd_ptr);
        rd_legal  = FWFT ? valid_q : !empty_q;
        wr_ok     = fifo.wr_en && !full_q && !busy;
        pop       = fifo.rd_en && rd_legal && !busy;
        arr_rd    = pop;
        valid_nxt = pop;
        // In fwft the output register refills from the array whenever it is
        // empty or being popped, so the head word falls through on its own.
        if (FWFT) begin
            arr_rd    = !busy && !arr_empty && (!valid_q || pop);
            valid_nxt = arr_rd || (valid_q && !pop);
        end
        count_nxt = count_q;
        case ({wr_ok, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            pf_q    <= 1'b0;
            pe_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + CW'(1);
            if (arr_rd) begin
                rd_ptr <= rd_ptr + CW'(1);
                dout_q <= mem[rd_ptr[AW-1:0]];
            end
            valid_q <= valid_nxt;
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            pf_q    <= (count_nxt >= PF_C);
            pe_q    <= (count_nxt <= PE_C);
            ovf_q   <= fifo.wr_en && !busy && !wr_ok;
            udf_q   <= fifo.rd_en && !busy && !pop;
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= fifo.din;
    end

    assign fifo.dout        = dout_q;
    assign fifo.valid       = valid_q;
    assign fifo.empty       = FWFT ? !valid_q : empty_q;
    assign fifo.full        = full_q | busy;
    assign fifo.prog_full   = pf_q | busy;
    assign fifo.prog_empty  = pe_q;
    assign fifo.data_count  = count_q;
    assign fifo.overflow    = ovf_q;
    assign fifo.underflow   = udf_q;
    assign fifo.wr_rst_busy = busy;
    assign fifo.rd_rst_busy = busy;
endmodule
